// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited ROM requests and buffers responses.
// Optional macro IFU_MISALIGN_CHECK_EN adds a registered misaligned-redirect error pulse.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_data_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i,
    output logic        if_err_o
);

    localparam int              PW       = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int              CW       = (FIFO_DEPTH > 3) ? 3 : 2;
    localparam logic [CW:0]     DEPTH_L  = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [CW:0]   credit_sum;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;
    logic [31:0]   jump_tgt;
    logic [63:0]   entry_flat [FIFO_DEPTH];
    logic [63:0]   head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Outstanding requests plus buffered words may never exceed the FIFO size,
    // so every response that is kept is guaranteed a free slot.
    assign credit_sum = {1'b0, out_q} + {1'b0, cnt_q};
    assign rom_req_o  = !rst && !jump_flag_i && (credit_sum < DEPTH_L);
    assign rom_addr_o = pc_q;

    assign grant    = rom_req_o && rom_gnt_i;
    assign resp     = rom_rvalid_i && (out_q != '0);
    assign push     = resp && (disc_q == '0) && !jump_flag_i;
    assign pop      = inst_valid_o && inst_ready_i && !jump_flag_i;
    assign jump_tgt = {jump_addr_i[31:2], 2'b00};

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        disc_d    = disc_q;
        cnt_d     = cnt_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        out_d     = out_q + CW'(grant) - CW'(resp);
        if (jump_flag_i) begin
            pc_d      = jump_tgt;
            resp_pc_d = jump_tgt;
            cnt_d     = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            // A response landing in the flush cycle is already excluded here.
            disc_d    = out_q - CW'(resp);
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [63:0] entry_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (push && (wr_ptr_q == PW'(gi))) begin
                    entry_q <= {resp_pc_q, rom_rdata_i};
                end
            end
            assign entry_flat[gi] = entry_q;
        end
    endgenerate

    assign head         = entry_flat[rd_ptr_q];
    assign inst_valid_o = (cnt_q != '0);
    assign inst_data_o  = inst_valid_o ? head[31:0]  : NOP;
    assign inst_addr_o  = inst_valid_o ? head[63:32] : 32'h0000_0000;

`ifdef IFU_MISALIGN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = jump_flag_i && (jump_addr_i[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign if_err_o = err_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, jump_addr_i[1:0]};
    assign if_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: transaction-level reference model, ROM with variable latency,
// and an independent in-order instruction stream check.
module tb_ifu_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i = 1'b0;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_data_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i = 1'b0;
    logic        if_err_o;

    ifu_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_data_o  (inst_data_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i),
        .if_err_o     (if_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [31:0] m_pc, m_rpc;
    int          m_out, m_disc;
    logic [63:0] m_fifo[$];
    logic        m_err;
    // ROM environment
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due;
    // stream scoreboard
    logic [31:0] exp_next;
    logic [31:0] acc_q[$];
    // stimulus knobs
    int pg, pr, kmin, kmax, pj;
    int first_gnt, first_valid, coinc;

`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] romf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic model_reset();
        m_pc = RPC;
        m_rpc = RPC;
        m_out = 0;
        m_disc = 0;
        m_fifo.delete();
        m_err = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        last_due = 0;
        exp_next = RPC;
    endtask

    // One clock cycle: drive at negedge, compare 1ns later, advance model at posedge.
    task automatic step(input bit fj, input logic [31:0] fja, input bit allow_j);
        bit          mreq, mvalid, mgrant, mrv;
        logic [31:0] tgt;
        int          due;
        jump_flag_i = fj || (allow_j && ($urandom_range(99) < pj));
        if (fj) jump_addr_i = fja;
        else if ($urandom_range(9) == 0) jump_addr_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else jump_addr_i = $urandom & 32'h0000_3FFF;
        rom_gnt_i    = ($urandom_range(99) < pg);
        inst_ready_i = ($urandom_range(99) < pr);
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = romf(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            rom_rvalid_i = 1'b0;
            rom_rdata_i  = $urandom;
        end
        #1;
        mreq   = !jump_flag_i && ((m_out + m_fifo.size()) < DEPTH);
        mvalid = (m_fifo.size() != 0);
        chk("rom_req",    rom_req_o,    mreq);
        chk("rom_addr",   rom_addr_o,   m_pc);
        chk("inst_valid", inst_valid_o, mvalid);
        chk("inst_data",  inst_data_o,  mvalid ? m_fifo[0][31:0]  : 32'h0000_0013);
        chk("inst_addr",  inst_addr_o,  mvalid ? m_fifo[0][63:32] : 32'h0);
        chk("if_err",     if_err_o,     m_err);
        if (inst_valid_o && inst_ready_i && !jump_flag_i) begin
            chk("stream_addr", inst_addr_o, exp_next);
            chk("stream_data", inst_data_o, romf(exp_next));
            acc_q.push_back(inst_addr_o);
            exp_next = exp_next + 32'd4;
        end
        if (jump_flag_i) exp_next = {jump_addr_i[31:2], 2'b00};
        if (jump_flag_i && rom_rvalid_i && inst_valid_o && inst_ready_i) coinc++;
        if (first_gnt < 0 && rom_req_o && rom_gnt_i) first_gnt = cyc;
        if (first_valid < 0 && inst_valid_o) first_valid = cyc;
        if (rom_req_o && rom_gnt_i) begin
            due = cyc + $urandom_range(kmax, kmin);
            if (due <= last_due) due = last_due + 1;
            pend_addr.push_back(rom_addr_o);
            pend_due.push_back(due);
            last_due = due;
        end
        @(posedge clk);
        mgrant = mreq && rom_gnt_i;
        mrv    = rom_rvalid_i && (m_out != 0);
        if (jump_flag_i) begin
            tgt    = {jump_addr_i[31:2], 2'b00};
            m_pc   = tgt;
            m_rpc  = tgt;
            m_fifo.delete();
            m_out  = m_out - int'(mrv);
            m_disc = m_out;
            m_err  = ERR_EN && (jump_addr_i[1:0] != 2'b00);
        end else begin
            if (mgrant) m_pc = m_pc + 32'd4;
            if (mvalid && inst_ready_i) void'(m_fifo.pop_front());
            if (mrv) begin
                if (m_disc != 0) m_disc--;
                else begin
                    m_fifo.push_back({m_rpc, rom_rdata_i});
                    m_rpc = m_rpc + 32'd4;
                end
            end
            m_out = m_out + int'(mgrant) - int'(mrv);
            m_err = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   rom_req_o,    32'h0);
        chk({tag, "_valid"}, inst_valid_o, 32'h0);
        chk({tag, "_data"},  inst_data_o,  32'h0000_0013);
        chk({tag, "_addr"},  inst_addr_o,  32'h0);
        chk({tag, "_err"},   if_err_o,     32'h0);
        chk({tag, "_pc"},    rom_addr_o,   RPC);
    endtask

    initial begin
        model_reset();
        first_gnt = -1;
        first_valid = -1;
        coinc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // streaming, k = 1, always granted and ready
        pg = 100; pr = 100; kmin = 1; kmax = 1; pj = 0;
        repeat (20) step(1'b0, 32'h0, 1'b0);
        chk("first_valid_lat", first_valid - first_gnt, 2);

        // stall: FIFO fills, requests stop
        pr = 0;
        repeat (10) step(1'b0, 32'h0, 1'b0);
        chk("stall_req_low", rom_req_o, 0);
        chk("stall_valid", inst_valid_o, 1);
        pr = 100;
        repeat (10) step(1'b0, 32'h0, 1'b0);

        // redirect to 0x100 with k = 3
        kmin = 3; kmax = 3;
        repeat (6) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0);
        acc_q.delete();
        repeat (15) step(1'b0, 32'h0, 1'b0);
        chk("redir_count_ge2", acc_q.size() >= 2, 1);
        if (acc_q.size() >= 2) begin
            chk("redir_first", acc_q[0], 32'h0000_0100);
            chk("redir_second", acc_q[1], 32'h0000_0104);
        end

        // misaligned redirect
        kmin = 1; kmax = 1;
        step(1'b1, 32'h0000_0102, 1'b0);
        chk("mis_fetch_addr", rom_addr_o, 32'h0000_0100);
        chk("mis_err_pulse", if_err_o, ERR_EN);
        step(1'b0, 32'h0, 1'b0);
        chk("mis_err_clear", if_err_o, 0);

        // random mix with frequent redirects
        pg = 70; pr = 70; kmin = 1; kmax = 4; pj = 15;
        repeat (2000) step(1'b0, 32'h0, 1'b1);
        chk("coincident_seen", coinc > 0, 1);

        // reset mid-stream with the FIFO full
        pg = 100; pr = 0; kmin = 1; kmax = 1; pj = 0;
        repeat (8) step(1'b0, 32'h0, 1'b0);
        chk("pre_rst_full", inst_valid_o && !rom_req_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req",   rom_req_o,    0);
        chk("midrst_valid", inst_valid_o, 0);
        chk("midrst_data",  inst_data_o,  32'h0000_0013);
        chk("midrst_addr",  inst_addr_o,  32'h0);
        chk("midrst_err",   if_err_o,     0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        pr = 100;
        repeat (12) step(1'b0, 32'h0, 1'b0);

        pg = 60; pr = 60; kmin = 1; kmax = 5; pj = 8;
        repeat (500) step(1'b0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
